// File: rtl/n_way_sum_pkg.sv
// Shared types and sizing helpers for the n-way FIFO summer.
package n_way_sum_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } sum_mode_e;

    // Width needed to hold the exact sum of n_inputs unsigned width-bit operands.
    function automatic int unsigned sum_w(input int unsigned width, input int unsigned n_inputs);
        return width + $clog2(n_inputs);
    endfunction

endpackage

// File: rtl/double_buffer_from_dally_harting.sv
// Two-slot in-order skid buffer; in_ready is registered so there is no ready-to-ready path.
module double_buffer_from_dally_harting #(
    parameter int unsigned width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_data
);
    logic [width-1:0] head_q, head_d, tail_q, tail_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             push, pop;

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = head_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (pop) begin
            head_d = tail_q;
            cnt_d  = cnt_d - 2'd1;
        end
        // New entry lands in whichever slot is next after any pop this cycle.
        if (push) begin
            if (cnt_d == 2'd0) begin
                head_d = in_data;
            end else begin
                tail_d = in_data;
            end
            cnt_d = cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/flip_flop_fifo_with_counter.sv
// Flip-flop FIFO with an occupancy counter; ready depends only on registered state.
module flip_flop_fifo_with_counter #(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_data
);
    localparam int unsigned PtrW = (depth > 1) ? $clog2(depth) : 1;
    localparam int unsigned CntW = $clog2(depth + 1);

    logic [width-1:0] mem_q [depth];
    logic [width-1:0] mem_d [depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push, pop;

    // A same-cycle pop never frees room for the push: ready is from count_q alone.
    assign in_ready  = (count_q != CntW'(depth));
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CntW'(push) - CntW'(pop);
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d = (wr_ptr_q == PtrW'(depth - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(depth - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/n_way_adder_sat.sv
// Combinational unsigned n-operand adder with overflow flag and optional saturation.
module n_way_adder_sat
    import n_way_sum_pkg::*;
#(
    parameter int unsigned width    = 8,
    parameter int unsigned n_inputs = 3,
    parameter sum_mode_e   saturate = MODE_WRAP
) (
    input  logic [n_inputs*width-1:0] operands,
    output logic [width-1:0]          sum_data,
    output logic                      overflow
);
    localparam int unsigned SumW = sum_w(width, n_inputs);

    logic [SumW-1:0] total;

    always_comb begin
        total = '0;
        for (int i = 0; i < int'(n_inputs); i++) begin
            total = total + SumW'(operands[i*width +: width]);
        end
        overflow = |total[SumW-1:width];
        if ((saturate == MODE_SAT) && overflow) begin
            sum_data = '1;
        end else begin
            sum_data = total[width-1:0];
        end
    end

endmodule

// File: rtl/n_way_sum_using_fifos_and_double_buffer.sv
// Joins n buffered operand streams, sums matching operands and emits via a double buffer.
module n_way_sum_using_fifos_and_double_buffer
    import n_way_sum_pkg::*;
#(
    parameter int unsigned width    = 8,
    parameter int unsigned depth    = 10,
    parameter int unsigned n_inputs = 3,
    parameter sum_mode_e   saturate = MODE_WRAP
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [n_inputs-1:0]       in_valid,
    output logic [n_inputs-1:0]       in_ready,
    input  logic [n_inputs*width-1:0] in_data,
    output logic                      sum_valid,
    input  logic                      sum_ready,
    output logic [width-1:0]          sum_data,
    output logic                      sum_overflow
);
    logic [n_inputs-1:0]       head_valid;
    logic [n_inputs*width-1:0] head_data;
    logic                      up_valid, up_ready, up_fire;
    logic [width-1:0]          up_sum;
    logic                      up_ovf;
    logic [width:0]            db_out;

    // All channels pop together so operand k always meets operand k of every other channel.
    assign up_valid = &head_valid;
    assign up_fire  = up_valid & up_ready;

    for (genvar i = 0; i < int'(n_inputs); i++) begin : g_chan
        flip_flop_fifo_with_counter #(
            .width (width),
            .depth (depth)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[i]),
            .in_ready  (in_ready[i]),
            .in_data   (in_data[i*width +: width]),
            .out_valid (head_valid[i]),
            .out_ready (up_fire),
            .out_data  (head_data[i*width +: width])
        );
    end

    n_way_adder_sat #(
        .width    (width),
        .n_inputs (n_inputs),
        .saturate (saturate)
    ) u_adder (
        .operands (head_data),
        .sum_data (up_sum),
        .overflow (up_ovf)
    );

    double_buffer_from_dally_harting #(
        .width (width + 1)
    ) u_dbuf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (up_valid),
        .in_ready  (up_ready),
        .in_data   ({up_ovf, up_sum}),
        .out_valid (sum_valid),
        .out_ready (sum_ready),
        .out_data  (db_out)
    );

    assign sum_overflow = db_out[width];
    assign sum_data     = db_out[width-1:0];

endmodule

// File: doc/n_way_sum_using_fifos_and_double_buffer.md
Name: n_way_sum_using_fifos_and_double_buffer

Overview:
- Generalised successor of the two-operand FIFO adder.
- Accepts n_inputs independent valid/ready operand streams, each buffered in its own flip-flop FIFO.
- When every FIFO holds an operand, pops all heads together and forms their unsigned sum in wrap or saturate mode, with an overflow flag.
- Result goes through a double buffer to a valid/ready output; sits between independent producers and one consumer.

Parameters:
- width, 8: operand and sum_data bit width.
- depth, 10: entries per input FIFO; must be >= 2.
- n_inputs, 3: number of operand channels; must be >= 2.
- saturate, 0: 0 gives sum modulo 2^width; 1 clamps the sum to 2^width-1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  n_inputs  per-channel operand valid.
- in_ready  out  n_inputs  per-channel operand ready.
- in_data  in  n_inputs*width  packed operands; channel i is bits [i*width +: width].
- sum_valid  out  1  result valid.
- sum_ready  in  1  downstream ready.
- sum_data  out  width  result (wrapped or saturated).
- sum_overflow  out  1  set when the true sum exceeded 2^width-1; qualified by sum_valid.

Behaviour:
- Reset, sampled at posedge with rst=1:
  - all FIFOs empty, so in_ready is all ones from the first cycle after reset;
  - both double-buffer slots empty, sum_valid=0, sum_data=0, sum_overflow=0.
- Reset mid-operation discards all queued operands and any buffered result without producing output.
- Input channel i:
  - in_ready[i] = ~fifo_full[i];
  - push[i] = in_valid[i] & in_ready[i].
  - A pop in the same cycle does not free space for that cycle's push, so a full FIFO stays not-ready until the cycle after a pop.
  - in_ready must not depend combinationally on in_valid or sum_ready.
- Join:
  - up_valid = AND over i of ~fifo_empty[i].
  - up_fire = up_valid & up_ready; on up_fire all n_inputs FIFOs pop together.
  - Channels are never popped individually, so operand k of every channel always combines with operand k of every other channel.
- Arithmetic:
  - Internal sum is width+$clog2(n_inputs) bits, zero-extended operands, no truncation.
  - overflow = (internal sum > 2^width-1).
  - saturate=0: sum_data = internal sum[width-1:0].
  - saturate=1: sum_data = overflow ? all ones : internal sum.
- Double buffer (two slots, holds {overflow, sum}):
  - up_ready = ~(both slots occupied); it is register-derived and has no combinational path from sum_ready.
  - Slot order is FIFO.
  - sum_valid, sum_data and sum_overflow hold stable while sum_valid & ~sum_ready.
- Latency:
  - Operand accepted at cycle t is at the FIFO head at t+1.
  - If all channels are present and up_ready, the result gives sum_valid at t+2.
- Throughput: one result per cycle sustained when sum_ready is held 1.
- Backpressure: with sum_ready=0, after 2 results are buffered up_ready=0; each FIFO then fills to depth and its in_ready drops.
- Simultaneous events:
  - push and pop on the same FIFO in one cycle leave the count unchanged;
  - the double buffer accepts and emits in one cycle when 1 slot is occupied and sum_ready=1.

Decomposition:
- Package n_way_sum_pkg: function sum_w(width, n_inputs) = width+$clog2(n_inputs), and enum sum_mode_e {MODE_WRAP=0, MODE_SAT=1} used for the saturate parameter.
- Reuse flip_flop_fifo_with_counter (generate loop, one per channel).
- Reuse double_buffer_from_dally_harting with width+1 for the {overflow, sum} payload.
- One new combinational sub-module, n_way_adder_sat(width, n_inputs, saturate): packed operands in, sum_data and overflow out.

Test Plan:
1. Defaults, saturate=0: push 10,20,30 on channels 0,1,2 in cycle 1, sum_ready=1 -> sum_valid at cycle 3, sum_data=60, sum_overflow=0; in_ready stays all ones.
2. saturate=0: operands 200,100,50 -> sum_data=94 (350 mod 256), overflow=1. Same operands with saturate=1 -> sum_data=255, overflow=1.
3. Skew: channel 0 pushes 5 operands at cycles 1-5, channels 1 and 2 push at cycles 10-14 -> no sum_valid before cycle 11; then 5 results in push order, one per cycle.
4. Backpressure, sum_ready=0, all channels streaming -> exactly 2 results buffered; each in_ready falls after 10 further accepts; sum_data stays stable. Release sum_ready -> all 12 results drain in order, none lost or duplicated.
5. Reset mid-stream with 4 operands queued and 1 result buffered: rst=1 for one cycle -> next cycle sum_valid=0, in_ready all ones, and no stale result appears afterwards.
6. n_inputs=2, depth=2, random valid/ready at 50% -> scoreboard matches every wrapped sum in order; in_ready never high while the FIFO is full.
